load_align_unit: RTL and testbench

Parametrised, sequential load data path between the LSU and data memory. It accepts one load at a time, issues one or two XLEN-wide aligned memory reads, and returns a right-justified, sign- or zero-extended result. Misaligned accesses that cross a word boundary are split into two reads and merged. It replaces the purely combinational mask/shift load formatting with a handshaked, XLEN-generic unit that supports misaligned accesses.

---
 rtl/load_align_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_align_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Handshaked load data path: issues one or two aligned memory reads per load and
// returns the right-justified, sign- or zero-extended result with its tag.
module load_align_unit #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 5,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_misaligned,
  output logic              rsp_fault
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [OFF_W-1:0] off_r;
  logic [2:0]       funct3_r;
  logic             cross_r;
  logic [XLEN-1:0]  beat0_r;
  logic [OFF_W-1:0] req_off_s;
  logic [4:0]       req_end_s;
  logic             req_cross_s, req_fault_s;
  logic [XLEN-1:0]  hi_s, lo_s, result_s;

  function automatic logic is_illegal(input logic [2:0] f3);
    logic bad;
    bad = (f3 == 3'b111);
    if (XLEN == 32) bad = bad | (f3 == 3'b011) | (f3 == 3'b110);
    else            bad = bad;
    return bad;
  endfunction

  // Keeps the low (8 << f3[1:0]) bits and fills the rest with sign or zero.
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] raw,
                                                  input logic [2:0] f3);
    logic [XLEN-1:0] val;
    int              nbits;
    logic            fill;
    nbits = 32'sd8 << f3[1:0];
    if (nbits > XLEN) nbits = XLEN;
    else              nbits = nbits;
    fill = ~f3[2] & raw[nbits-1];
    for (int i = 0; i < XLEN; i++) begin
      if (i >= nbits) val[i] = fill;
      else            val[i] = raw[i];
    end
    return val;
  endfunction

  // Request classification: offset, word-boundary crossing, fault.
  always_comb begin
    req_off_s   = req_addr[OFF_W-1:0];
    req_end_s   = 5'(req_off_s) + (5'd1 << req_funct3[1:0]);
    req_cross_s = (req_end_s > 5'(BYTES));
    req_fault_s = is_illegal(req_funct3) | (req_cross_s & ~SPLIT_EN);
  end

  // Merge window: second beat sits above the first; single-beat loads see zeros.
  always_comb begin
    if (state_r == WAIT1) begin
      hi_s = mem_resp_data;
      lo_s = beat0_r;
    end else begin
      hi_s = {XLEN{1'b0}};
      lo_s = mem_resp_data;
    end
    result_s = format_load(XLEN'({hi_s, lo_s} >> {off_r, 3'b000}), funct3_r);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = req_fault_s ? RESP : REQ0;
        else           state_s = IDLE;
      end
      REQ0: begin
        if (mem_req_ready) state_s = WAIT0;
        else               state_s = REQ0;
      end
      WAIT0: begin
        if (mem_resp_valid) state_s = cross_r ? REQ1 : RESP;
        else                state_s = WAIT0;
      end
      REQ1: begin
        if (mem_req_ready) state_s = WAIT1;
        else               state_s = REQ1;
      end
      WAIT1: begin
        if (mem_resp_valid) state_s = RESP;
        else                state_s = WAIT1;
      end
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Captured request, beat buffer and registered response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r          <= {OFF_W{1'b0}};
      funct3_r       <= 3'b000;
      cross_r        <= 1'b0;
      beat0_r        <= {XLEN{1'b0}};
      mem_req_addr   <= {ADDR_W{1'b0}};
      rsp_data       <= {XLEN{1'b0}};
      rsp_tag        <= {TAG_W{1'b0}};
      rsp_misaligned <= 1'b0;
      rsp_fault      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            off_r    <= req_off_s;
            funct3_r <= req_funct3;
            cross_r  <= req_cross_s;
            rsp_tag  <= req_tag;
            if (req_fault_s) begin
              rsp_fault      <= 1'b1;
              rsp_data       <= {XLEN{1'b0}};
              rsp_misaligned <= 1'b0;
            end else begin
              rsp_fault    <= 1'b0;
              mem_req_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        WAIT0: begin
          if (mem_resp_valid) begin
            beat0_r <= mem_resp_data;
            if (cross_r) begin
              mem_req_addr <= mem_req_addr + ADDR_W'(BYTES);
            end else begin
              rsp_data       <= result_s;
              rsp_misaligned <= 1'b0;
            end
          end
        end
        WAIT1: begin
          if (mem_resp_valid) begin
            rsp_data       <= result_s;
            rsp_misaligned <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready     = (state_r == IDLE);
  assign mem_req_valid = (state_r == REQ0) || (state_r == REQ1);
  assign rsp_valid     = (state_r == RESP);

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench: XLEN=32 split unit, XLEN=32 no-split unit, XLEN=64 unit.
module tb_load_align_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] req_addr      = 32'h0;
  logic [2:0]  req_funct3    = 3'b000;
  logic [4:0]  req_tag       = 5'd0;
  logic        rsp_ready     = 1'b0;
  logic        mem_req_ready = 1'b1;
  logic        req_valid = 1'b0, req_valid_ns = 1'b0, req_valid64 = 1'b0;

  logic        req_ready, mem_req_valid, rsp_valid, rsp_misaligned, rsp_fault;
  logic [31:0] mem_req_addr, rsp_data;
  logic [4:0]  rsp_tag;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data  = 32'h0;

  logic        req_ready_ns, mem_req_valid_ns, rsp_valid_ns, rsp_misaligned_ns, rsp_fault_ns;
  logic [31:0] mem_req_addr_ns, rsp_data_ns;
  logic [4:0]  rsp_tag_ns;

  logic        req_ready64, mem_req_valid64, rsp_valid64, rsp_misaligned64, rsp_fault64;
  logic [31:0] mem_req_addr64;
  logic [63:0] rsp_data64;
  logic [4:0]  rsp_tag64;
  logic        mem_resp_valid64 = 1'b0;
  logic [63:0] mem_resp_data64  = 64'h0;

  load_align_unit #(.XLEN(32), .ADDR_W(32), .TAG_W(5), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault));

  load_align_unit #(.XLEN(32), .ADDR_W(32), .TAG_W(5), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid_ns), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr_ns),
    .mem_resp_valid(1'b0), .mem_resp_data(32'h0),
    .rsp_valid(rsp_valid_ns), .rsp_ready(rsp_ready), .rsp_data(rsp_data_ns), .rsp_tag(rsp_tag_ns),
    .rsp_misaligned(rsp_misaligned_ns), .rsp_fault(rsp_fault_ns));

  load_align_unit #(.XLEN(64), .ADDR_W(32), .TAG_W(5), .SPLIT_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid64), .req_ready(req_ready64),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr64),
    .mem_resp_valid(mem_resp_valid64), .mem_resp_data(mem_resp_data64),
    .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready), .rsp_data(rsp_data64), .rsp_tag(rsp_tag64),
    .rsp_misaligned(rsp_misaligned64), .rsp_fault(rsp_fault64));

  function automatic logic [31:0] mem32(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h8765_4321;
      32'h0000_0104: return 32'hFFEE_DDCC;
      32'hFFFF_FFFC: return 32'h1122_3344;
      32'h0000_0000: return 32'h5566_7788;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [63:0] mem64(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 64'h0807_0605_0403_0201;
      32'h0000_0108: return 64'h900F_0E0D_0C0B_0A09;
      default:       return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  // Memory models: one-cycle read latency, logging every accepted address.
  logic [31:0] rd_log   [0:63];
  logic [31:0] rd64_log [0:15];
  int rd_cnt = 0, rd64_cnt = 0, ns_req_cnt = 0;

  always @(posedge clk) begin
    mem_resp_valid <= 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      mem_resp_valid         <= 1'b1;
      mem_resp_data          <= mem32(mem_req_addr);
      rd_log[rd_cnt[5:0]]    <= mem_req_addr;
      rd_cnt                 <= rd_cnt + 1;
    end
  end

  always @(posedge clk) begin
    mem_resp_valid64 <= 1'b0;
    if (mem_req_valid64 && mem_req_ready) begin
      mem_resp_valid64        <= 1'b1;
      mem_resp_data64         <= mem64(mem_req_addr64);
      rd64_log[rd64_cnt[3:0]] <= mem_req_addr64;
      rd64_cnt                <= rd64_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (mem_req_valid_ns) ns_req_cnt <= ns_req_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] V_ADDR [0:7] = '{32'h103, 32'h103, 32'h102, 32'h102,
                                           32'h103, 32'h101, 32'h100, 32'h106};
  localparam logic [2:0]  V_F3   [0:7] = '{3'b000, 3'b100, 3'b101, 3'b010,
                                           3'b001, 3'b001, 3'b010, 3'b101};
  localparam logic [31:0] V_DATA [0:7] = '{32'hFFFF_FF87, 32'h0000_0087, 32'h0000_8765, 32'hDDCC_8765,
                                           32'hFFFF_CC87, 32'h0000_6543, 32'h8765_4321, 32'h0000_FFEE};
  localparam logic        V_MIS  [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic got_rsp(input int which);
    if (which == 0)      return rsp_valid;
    else if (which == 1) return rsp_valid_ns;
    else                 return rsp_valid64;
  endfunction

  // Accepts at edge t; lat=k means rsp_valid first seen after edge t+k-1.
  task automatic do_load(input int which, input logic [31:0] a, input logic [2:0] f3,
                         input logic [4:0] tg, output int lat);
    @(negedge clk);
    req_addr = a; req_funct3 = f3; req_tag = tg;
    if (which == 0)      req_valid   = 1'b1;
    else if (which == 1) req_valid_ns = 1'b1;
    else                 req_valid64 = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid_ns = 1'b0; req_valid64 = 1'b0;
    lat = 1;
    while (!got_rsp(which) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_rsp;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({req_ready, mem_req_valid, rsp_valid, rsp_misaligned, rsp_fault} !== 5'b10000 ||
        rsp_data !== 32'h0 || rsp_tag !== 5'd0 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset32: rdy/mv/rv/mis/flt=%b data=%h tag=%h addr=%h want 10000 0 0 0",
               {req_ready, mem_req_valid, rsp_valid, rsp_misaligned, rsp_fault}, rsp_data, rsp_tag, mem_req_addr);
    end
    checks++;
    if ({req_ready64, mem_req_valid64, rsp_valid64, rsp_fault64} !== 4'b1000 || rsp_data64 !== 64'h0 ||
        {req_ready_ns, rsp_valid_ns, rsp_fault_ns} !== 3'b100) begin
      errors++;
      $display("FAIL reset_others: r64=%b d64=%h rns=%b want 1000 0 100",
               {req_ready64, mem_req_valid64, rsp_valid64, rsp_fault64}, rsp_data64,
               {req_ready_ns, rsp_valid_ns, rsp_fault_ns});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_formatting;
    int base, lat, exp_lat;
    for (int i = 0; i < 8; i++) begin
      base = rd_cnt;
      do_load(0, V_ADDR[i], V_F3[i], 5'(i + 1), lat);
      exp_lat = V_MIS[i] ? 5 : 3;
      checks++;
      if (lat !== exp_lat || rsp_data !== V_DATA[i]) begin
        errors++;
        $display("FAIL fmt[%0d]: lat=%0d data=%h want lat=%0d data=%h", i, lat, rsp_data, exp_lat, V_DATA[i]);
      end
      checks++;
      if (rsp_misaligned !== V_MIS[i] || rsp_fault !== 1'b0 || rsp_tag !== 5'(i + 1) ||
          rd_cnt != base + (V_MIS[i] ? 2 : 1)) begin
        errors++;
        $display("FAIL flags[%0d]: mis=%b flt=%b tag=%0d reads=%0d want mis=%b flt=0 tag=%0d",
                 i, rsp_misaligned, rsp_fault, rsp_tag, rd_cnt - base, V_MIS[i], i + 1);
      end
      release_rsp;
    end
  endtask

  task automatic test_split_addr;
    int base, lat;
    base = rd_cnt;
    do_load(0, 32'h102, 3'b010, 5'd7, lat);
    checks++;
    if (rd_log[base] !== 32'h100 || rd_log[base + 1] !== 32'h104 || rsp_tag !== 5'd7) begin
      errors++;
      $display("FAIL split_addr: a0=%h a1=%h tag=%0d want 100 104 7", rd_log[base], rd_log[base + 1], rsp_tag);
    end
    release_rsp;
  endtask

  task automatic test_wrap_stall;
    int base, lat;
    base = rd_cnt;
    @(negedge clk);
    mem_req_ready = 1'b0;
    req_addr = 32'hFFFF_FFFE; req_funct3 = 3'b010; req_tag = 5'd11; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC || req_ready !== 1'b0 ||
          rsp_valid !== 1'b0 || rd_cnt != base) begin
        errors++;
        $display("FAIL stall_hold[%0d]: mv=%b addr=%h rdy=%b want mv=1 addr=fffffffc rdy=0", i,
                 mem_req_valid, mem_req_addr, req_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); mem_req_ready = 1'b1;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h7788_1122 || rsp_misaligned !== 1'b1 || rsp_tag !== 5'd11) begin
      errors++;
      $display("FAIL wrap_data: v=%b data=%h mis=%b tag=%0d want 1 77881122 1 11",
               rsp_valid, rsp_data, rsp_misaligned, rsp_tag);
    end
    checks++;
    if (rd_log[base] !== 32'hFFFF_FFFC || rd_log[base + 1] !== 32'h0 || rd_cnt != base + 2) begin
      errors++;
      $display("FAIL wrap_addr: a0=%h a1=%h n=%0d want fffffffc 00000000 2",
               rd_log[base], rd_log[base + 1], rd_cnt - base);
    end
    release_rsp;
  endtask

  task automatic test_fault;
    int base, lat;
    base = rd_cnt;
    do_load(0, 32'h100, 3'b011, 5'd9, lat);
    checks++;
    if (lat !== 1 || rsp_fault !== 1'b1 || rsp_data !== 32'h0 || rsp_misaligned !== 1'b0 ||
        rsp_tag !== 5'd9 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_f3: lat=%0d flt=%b data=%h tag=%0d mv=%b want 1 1 0 9 0",
               lat, rsp_fault, rsp_data, rsp_tag, mem_req_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_data !== 32'h0 || rsp_tag !== 5'd9 ||
          req_ready !== 1'b0 || rd_cnt != base) begin
        errors++;
        $display("FAIL fault_hold[%0d]: v=%b flt=%b data=%h rdy=%b reads=%0d want 1 1 0 0 0", i,
                 rsp_valid, rsp_fault, rsp_data, req_ready, rd_cnt - base);
      end
    end
    release_rsp;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_release: rdy=%b v=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_no_split;
    int lat;
    do_load(1, 32'h102, 3'b010, 5'd4, lat);
    checks++;
    if (lat !== 1 || rsp_fault_ns !== 1'b1 || rsp_data_ns !== 32'h0 || rsp_misaligned_ns !== 1'b0 ||
        rsp_tag_ns !== 5'd4 || req_ready_ns !== 1'b0 || ns_req_cnt != 0 || mem_req_addr_ns !== 32'h0) begin
      errors++;
      $display("FAIL no_split: lat=%0d flt=%b data=%h tag=%0d memreqs=%0d want 1 1 0 4 0",
               lat, rsp_fault_ns, rsp_data_ns, rsp_tag_ns, ns_req_cnt);
    end
    release_rsp;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_addr = 32'h102; req_funct3 = 3'b010; req_tag = 5'd13; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        rsp_data !== 32'h0 || mem_req_addr !== 32'h0 || rsp_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b v=%b mv=%b data=%h addr=%h want 1 0 0 0 0",
               req_ready, rsp_valid, mem_req_valid, rsp_data, mem_req_addr);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL late_resp[%0d]: v=%b rdy=%b mv=%b want 0 1 0", i, rsp_valid, req_ready, mem_req_valid);
      end
    end
  endtask

  task automatic test_xlen64;
    int base, lat;
    base = rd64_cnt;
    do_load(2, 32'h104, 3'b011, 5'd2, lat);
    checks++;
    if (lat !== 5 || rsp_data64 !== 64'h0C0B_0A09_0807_0605 || rsp_misaligned64 !== 1'b1 ||
        rsp_fault64 !== 1'b0 || rsp_tag64 !== 5'd2) begin
      errors++;
      $display("FAIL ld64: lat=%0d data=%h mis=%b flt=%b want 5 0c0b0a0908070605 1 0",
               lat, rsp_data64, rsp_misaligned64, rsp_fault64);
    end
    checks++;
    if (rd64_log[base] !== 32'h100 || rd64_log[base + 1] !== 32'h108 || rd64_cnt != base + 2) begin
      errors++;
      $display("FAIL ld64_addr: a0=%h a1=%h want 100 108", rd64_log[base], rd64_log[base + 1]);
    end
    release_rsp;
    do_load(2, 32'h10C, 3'b010, 5'd5, lat);
    checks++;
    if (lat !== 3 || rsp_data64 !== 64'hFFFF_FFFF_900F_0E0D || rsp_misaligned64 !== 1'b0) begin
      errors++;
      $display("FAIL lw64: lat=%0d data=%h want 3 ffffffff900f0e0d", lat, rsp_data64);
    end
    release_rsp;
    do_load(2, 32'h10C, 3'b110, 5'd6, lat);
    checks++;
    if (lat !== 3 || rsp_data64 !== 64'h0000_0000_900F_0E0D || rsp_fault64 !== 1'b0) begin
      errors++;
      $display("FAIL lwu64: lat=%0d data=%h want 3 00000000900f0e0d", lat, rsp_data64);
    end
    release_rsp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_formatting();
    test_split_addr();
    test_fault();
    test_no_split();
    test_wrap_stall();
    test_reset_mid();
    test_xlen64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
